// File: rtl/gcd_engine.sv
// GCD engine: valid/ready operand intake, per-cycle Euclid or Stein iteration,
// result held on a valid/ready output together with the iteration count.
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int MODE  = 0,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CW-1:0]    cycles,
    output logic             busy
);
    localparam int KW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a, b, a_nxt, b_nxt, gcd_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic             finish, load;

    assign in_ready  = (state == IDLE) && !clr;
    assign busy      = (state == CALC);
    assign out_valid = (state == DONE);
    assign load      = in_valid && in_ready;

    // One iteration step; the termination test always takes priority.
    always_comb begin
        a_nxt   = a;
        b_nxt   = b;
        k_nxt   = k;
        gcd_nxt = gcd_out;
        finish  = 1'b0;
        if (MODE == 0) begin
            if (b == '0) begin
                finish  = 1'b1;
                gcd_nxt = a;
            end else if (a < b) begin
                a_nxt = b;
                b_nxt = a;
            end else begin
                a_nxt = a - b;
            end
        end else begin
            if (a == '0) begin
                finish  = 1'b1;
                gcd_nxt = b << k;
            end else if (b == '0) begin
                finish  = 1'b1;
                gcd_nxt = a << k;
            end else if (!a[0] && !b[0]) begin
                a_nxt = a >> 1;
                b_nxt = b >> 1;
                k_nxt = k + KW'(1);
            end else if (!a[0]) begin
                a_nxt = a >> 1;
            end else if (!b[0]) begin
                b_nxt = b >> 1;
            end else if (a >= b) begin
                a_nxt = (a - b) >> 1;
            end else begin
                b_nxt = (b - a) >> 1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CALC;
            CALC:    if (finish) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // An abort freezes the datapath so the last result stays readable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= '0;
            b       <= '0;
            k       <= '0;
            gcd_out <= '0;
            cycles  <= '0;
        end else if (!clr) begin
            if (load) begin
                a      <= a_in;
                b      <= b_in;
                k      <= '0;
                cycles <= '0;
            end else if (state == CALC) begin
                a       <= a_nxt;
                b       <= b_nxt;
                k       <= k_nxt;
                gcd_out <= gcd_nxt;
                if (cycles != CMAX) cycles <= cycles + CW'(1);
            end
        end
    end
endmodule
